// File: rtl/mem_port_arbiter_pkg.sv
// mips_pkg: shared state encoding, counter width and default bus widths for mem_port_arbiter.
package mips_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2,
    DONE   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch port, load/store port and RAM port of the shared-RAM arbiter.
interface mem_port_arbiter_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic              mem_stall;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [15:0]       conflict_cnt;

  // master: pipeline + RAM side; slave: the arbiter
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata, conflict_cnt
  );
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           ram_en, ram_we, ram_addr, ram_wdata, conflict_cnt
  );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// arb_lat_counter: loadable down-counter timing the RAM read latency; stops at zero.
module arb_lat_counter
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (i_load)          r_cnt <= i_val;
    else if (r_cnt != '0)     r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency RAM between IF fetch and MEM load/store, data first.
// Build option MEM_ARB_STATS_EN enables the saturating contention counter on conflict_cnt.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  arb_state_t        r_state;
  logic              r_last_d;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata, r_if_rdata, r_mem_rdata;
  logic              r_if_valid, r_mem_valid;
  logic              w_issue_d, w_issue_i, w_issue, w_lat_zero;
  logic              w_if_stall, w_mem_stall;

  // In DONE the port just served still holds its request, so only the other port may issue.
  assign w_issue_d = bus.mem_req &&
                     ((r_state == IDLE) || (r_state == DONE && !r_last_d));
  assign w_issue_i = bus.if_req && !w_issue_d &&
                     ((r_state == IDLE) || (r_state == DONE && r_last_d));
  assign w_issue   = w_issue_d || w_issue_i;

  arb_lat_counter u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_issue),
    .i_val  (CNT_W'(MEM_LAT)),
    .o_zero (w_lat_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
    end else begin
      r_ram_en    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_issue_d) begin
            r_state     <= BUSY_D;
            r_ram_en    <= 1'b1;
            r_ram_we    <= bus.mem_we;
            r_ram_addr  <= bus.mem_addr;
            r_ram_wdata <= bus.mem_wdata;
          end else if (w_issue_i) begin
            r_state    <= BUSY_I;
            r_ram_en   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= bus.if_addr;
          end else begin
            r_state <= IDLE;
          end
        end
        BUSY_D: if (w_lat_zero) begin
          if (!r_ram_we) r_mem_rdata <= bus.ram_rdata;
          r_mem_valid <= 1'b1;
          r_last_d    <= 1'b1;
          r_state     <= DONE;
        end
        BUSY_I: if (w_lat_zero) begin
          r_if_rdata <= bus.ram_rdata;
          r_if_valid <= 1'b1;
          r_last_d   <= 1'b0;
          r_state    <= DONE;
        end
      endcase
    end
  end

  // Stalls are gated by reset so every output reads 0 while reset is held.
  assign w_if_stall  = rst_n && bus.if_req  && !r_if_valid;
  assign w_mem_stall = rst_n && bus.mem_req && !r_mem_valid;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_conflict_cnt <= '0;
    else if (w_if_stall && w_mem_stall && r_conflict_cnt != 16'hFFFF)
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
  end
  assign bus.conflict_cnt = r_conflict_cnt;
`else
  assign bus.conflict_cnt = '0;
`endif

  assign bus.if_rdata  = r_if_rdata;
  assign bus.if_valid  = r_if_valid;
  assign bus.if_stall  = w_if_stall;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_stall = w_mem_stall;
  assign bus.ram_en    = r_ram_en;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed timing scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
`ifdef MEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   gcyc = 0;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  // RAM contents as written through the DUT, and the bench's own view of memory
  logic [31:0] ram_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] pend_d [16];
  bit          pend_v [16];
  int          slot;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ram_read(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  // Fixed-latency RAM: data valid exactly LAT cycles after the ram_en cycle, junk otherwise
  always @(negedge clk) begin
    slot = gcyc % 16;
    if (pend_v[slot]) begin
      bus.ram_rdata = pend_d[slot];
      pend_v[slot]  = 1'b0;
    end else begin
      bus.ram_rdata = $urandom;
    end
    if (bus.ram_en) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] = bus.ram_wdata;
      else begin
        pend_d[(gcyc + LAT) % 16] = ram_read(bus.ram_addr);
        pend_v[(gcyc + LAT) % 16] = 1'b1;
      end
    end
  end

  // Per-cycle record of a directed run; bit k / index k is cycle k
  logic [31:0] rv_en, rv_we, rv_iv, rv_mv, rv_is, rv_ms, rv_zero;
  logic [31:0] ra_addr [32];
  logic [31:0] ra_wd   [32];
  logic [31:0] ra_ird  [32];
  logic [31:0] ra_mrd  [32];
  logic [15:0] ra_cc   [32];

  function automatic bit outs_zero();
    return ({bus.ram_en, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.if_valid, bus.mem_valid,
             bus.if_rdata, bus.mem_rdata, bus.if_stall, bus.mem_stall, bus.conflict_cnt} == '0);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Caller raises requests at the start of cycle 0; requests drop (or advance) after their valid
  task automatic run(input int n, input bit if_keep, input int rst_at, input int rst_rel);
    rv_en = '0; rv_we = '0; rv_iv = '0; rv_mv = '0; rv_is = '0; rv_ms = '0; rv_zero = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rv_en[k] = bus.ram_en;    rv_we[k] = bus.ram_we;
      rv_iv[k] = bus.if_valid;  rv_mv[k] = bus.mem_valid;
      rv_is[k] = bus.if_stall;  rv_ms[k] = bus.mem_stall;
      rv_zero[k] = outs_zero();
      ra_addr[k] = bus.ram_addr; ra_wd[k] = bus.ram_wdata;
      ra_ird[k] = bus.if_rdata;  ra_mrd[k] = bus.mem_rdata; ra_cc[k] = bus.conflict_cnt;
      @(posedge clk); #1;
      if (k + 1 == rst_at)  rst_n = 1'b0;
      if (k + 1 == rst_rel) rst_n = 1'b1;
      if (rv_iv[k]) begin
        if (if_keep) bus.if_addr = bus.if_addr + 32'd4;
        else bus.if_req = 1'b0;
      end
      if (rv_mv[k]) bus.mem_req = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req = 1'b1; bus.mem_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (!outs_zero()) begin n_err++; $display("FAIL reset_outputs: not all zero with requests high"); end
    do_reset();
    @(negedge clk);
    n_cmp++; if (!outs_zero()) begin n_err++; $display("FAIL reset_idle: outputs not zero after release"); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h0040_0000;
    run(8, 1'b0, -1, -1);
    n_cmp++; if (rv_en !== 32'h2) begin n_err++; $display("FAIL fetch_ram_en: got %h want %h", rv_en, 32'h2); end
    n_cmp++; if (rv_we[1] !== 1'b0 || ra_addr[1] !== 32'h0040_0000) begin n_err++;
      $display("FAIL fetch_ram_cmd: we=%b addr=%h want we=0 addr=00400000", rv_we[1], ra_addr[1]); end
    n_cmp++; if (rv_iv !== 32'h10) begin n_err++; $display("FAIL fetch_valid: got %h want %h", rv_iv, 32'h10); end
    n_cmp++; if (ra_ird[4] !== 32'h2008_0005) begin n_err++; $display("FAIL fetch_rdata: got %h want 20080005", ra_ird[4]); end
    n_cmp++; if (rv_is !== 32'h0F) begin n_err++; $display("FAIL fetch_stall: got %h want %h", rv_is, 32'h0F); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] ia, ma;
    ia = 32'h0040_0100; ma = 32'h1000_0010;
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = ia;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = ma;
    run(10, 1'b0, -1, -1);
    n_cmp++; if (rv_en !== 32'h22) begin n_err++; $display("FAIL simul_ram_en: got %h want %h", rv_en, 32'h22); end
    n_cmp++; if (ra_addr[1] !== ma || ra_addr[5] !== ia || rv_we[1] !== 1'b0) begin n_err++;
      $display("FAIL simul_order: addr1=%h addr5=%h want %h %h", ra_addr[1], ra_addr[5], ma, ia); end
    n_cmp++; if (rv_mv !== 32'h10 || rv_iv !== 32'h100) begin n_err++;
      $display("FAIL simul_valid: mem=%h if=%h want 10 100", rv_mv, rv_iv); end
    n_cmp++; if (ra_mrd[4] !== ref_read(ma) || ra_ird[8] !== ref_read(ia)) begin n_err++;
      $display("FAIL simul_rdata: mem=%h if=%h want %h %h", ra_mrd[4], ra_ird[8], ref_read(ma), ref_read(ia)); end
    n_cmp++; if (rv_ms !== 32'h0F || rv_is !== 32'hFF) begin n_err++;
      $display("FAIL simul_stall: mem=%h if=%h want 0f ff", rv_ms, rv_is); end
    n_cmp++; if (ra_cc[9] !== (STATS ? 16'd4 : 16'd0)) begin n_err++;
      $display("FAIL simul_conflict: got %0d want %0d", ra_cc[9], STATS ? 4 : 0); end
  endtask

  // Runs straight after test_simultaneous so mem_rdata holds that load's data
  task automatic test_store();
    logic [31:0] prev;
    prev = ref_read(32'h1000_0010);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 32'h1000_0020; bus.mem_wdata = 32'hDEAD_BEEF;
    run(8, 1'b0, -1, -1);
    ref_mem[32'h1000_0020] = 32'hDEAD_BEEF;
    n_cmp++; if (rv_en !== 32'h2 || rv_we[1] !== 1'b1) begin n_err++;
      $display("FAIL store_ram_en: en=%h we=%b want 2 1", rv_en, rv_we[1]); end
    n_cmp++; if (ra_addr[1] !== 32'h1000_0020 || ra_wd[1] !== 32'hDEAD_BEEF) begin n_err++;
      $display("FAIL store_ram_cmd: addr=%h wdata=%h want 10000020 deadbeef", ra_addr[1], ra_wd[1]); end
    n_cmp++; if (rv_mv !== 32'h10) begin n_err++; $display("FAIL store_valid: got %h want 10", rv_mv); end
    n_cmp++; if (ra_mrd[6] !== prev) begin n_err++; $display("FAIL store_rdata_hold: got %h want %h", ra_mrd[6], prev); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ia;
    ia = 32'h0040_0200;
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = ia;
    run(12, 1'b0, 2, 4);
    n_cmp++; if (rv_zero[2] !== 1'b1 || rv_zero[3] !== 1'b1) begin n_err++;
      $display("FAIL rstmid_zero: cyc2=%b cyc3=%b want 1 1", rv_zero[2], rv_zero[3]); end
    n_cmp++; if (rv_en !== 32'h22) begin n_err++; $display("FAIL rstmid_ram_en: got %h want 22", rv_en); end
    n_cmp++; if (rv_iv !== 32'h100) begin n_err++; $display("FAIL rstmid_valid: got %h want 100", rv_iv); end
    n_cmp++; if (ra_ird[7] !== 32'h0 || ra_ird[8] !== ref_read(ia)) begin n_err++;
      $display("FAIL rstmid_rdata: c7=%h c8=%h want 0 %h", ra_ird[7], ra_ird[8], ref_read(ia)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    a = 32'h0040_0300;
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = a;
    run(16, 1'b1, -1, -1);
    n_cmp++; if (rv_en !== 32'h842) begin n_err++; $display("FAIL b2b_ram_en: got %h want 842", rv_en); end
    n_cmp++; if (rv_iv !== 32'h4210) begin n_err++; $display("FAIL b2b_valid: got %h want 4210", rv_iv); end
    n_cmp++; if (ra_addr[6] !== a + 32'd4 || ra_addr[11] !== a + 32'd8) begin n_err++;
      $display("FAIL b2b_addr: c6=%h c11=%h want %h %h", ra_addr[6], ra_addr[11], a + 32'd4, a + 32'd8); end
    n_cmp++; if (ra_ird[9] !== ref_read(a + 32'd4) || ra_ird[14] !== ref_read(a + 32'd8)) begin n_err++;
      $display("FAIL b2b_rdata: c9=%h c14=%h want %h %h", ra_ird[9], ra_ird[14], ref_read(a + 32'd4), ref_read(a + 32'd8)); end
    bus.if_req = 1'b0;
  endtask

  task automatic test_random();
    bit ip = 0, mp = 0, idone = 0, mdone = 0, mwe = 0, abort = 0, ok;
    logic [31:0] ia = 0, ma = 0, mwd = 0, iexp = 0, mexp = 0, last_ld = 0;
    int iage = 0, mage = 0, exp_i_c = -1, exp_d_c = -1, conf = 0;
    do_reset();
    for (int c = 0; c < 3000 && !abort; c++) begin
      if (idone) begin idone = 0; ip = 0; end
      if (mdone) begin mdone = 0; mp = 0; end
      if (!ip && $urandom_range(0, 2) != 0) begin
        ip = 1; ia = 32'h0040_0000 + 32'($urandom_range(0, 15)) * 32'd4; iexp = ref_read(ia); iage = 0;
      end
      if (!mp && $urandom_range(0, 2) == 0) begin
        mp = 1; ma = 32'h1000_0000 + 32'($urandom_range(0, 7)) * 32'd4;
        mwe = 1'($urandom_range(0, 1)); mwd = $urandom; mexp = ref_read(ma); mage = 0;
      end
      bus.if_req = ip; bus.if_addr = ia;
      bus.mem_req = mp; bus.mem_we = mwe; bus.mem_addr = ma; bus.mem_wdata = mwd;
      @(negedge clk);
      n_cmp++; if (bus.if_stall !== (ip && !bus.if_valid)) begin n_err++;
        $display("FAIL rnd_if_stall c%0d: got %b want %b", c, bus.if_stall, ip && !bus.if_valid); end
      n_cmp++; if (bus.mem_stall !== (mp && !bus.mem_valid)) begin n_err++;
        $display("FAIL rnd_mem_stall c%0d: got %b want %b", c, bus.mem_stall, mp && !bus.mem_valid); end
      if (c == exp_i_c) begin
        n_cmp++; if (!(bus.ram_en && !bus.ram_we && bus.ram_addr == ia)) begin n_err++;
          $display("FAIL rnd_fetch_after_data c%0d: en=%b addr=%h want 1 %h", c, bus.ram_en, bus.ram_addr, ia); end
      end
      if (c == exp_d_c) begin
        n_cmp++; if (!(bus.ram_en && bus.ram_we == mwe && bus.ram_addr == ma)) begin n_err++;
          $display("FAIL rnd_data_after_fetch c%0d: en=%b addr=%h want 1 %h", c, bus.ram_en, bus.ram_addr, ma); end
      end
      if (bus.ram_en) begin
        ok = bus.ram_we ? (mp && mwe && bus.ram_addr == ma && bus.ram_wdata == mwd)
                        : ((ip && bus.ram_addr == ia) || (mp && !mwe && bus.ram_addr == ma));
        n_cmp++; if (!ok) begin n_err++;
          $display("FAIL rnd_ram_cmd c%0d: we=%b addr=%h wd=%h matches no pending request", c, bus.ram_we, bus.ram_addr, bus.ram_wdata); end
      end
      if (ip && !bus.if_valid && mp && !bus.mem_valid && conf != 65535) conf++;
      if (bus.if_valid) begin
        n_cmp++; if (!ip || bus.if_rdata !== iexp) begin n_err++;
          $display("FAIL rnd_if_data c%0d: pend=%b got %h want %h", c, ip, bus.if_rdata, iexp); end
        idone = 1;
        if (mp && !bus.mem_valid) exp_d_c = c + 1;
      end
      if (bus.mem_valid) begin
        n_cmp++; if (!mp || bus.mem_rdata !== (mwe ? last_ld : mexp)) begin n_err++;
          $display("FAIL rnd_mem_data c%0d: pend=%b we=%b got %h want %h", c, mp, mwe, bus.mem_rdata, mwe ? last_ld : mexp); end
        if (mwe) ref_mem[ma] = mwd; else last_ld = mexp;
        mdone = 1;
        if (ip && !bus.if_valid) exp_i_c = c + 1;
      end
      if (ip && !idone) iage++;
      if (mp && !mdone) mage++;
      if (iage > 6 * (LAT + 3) || mage > 6 * (LAT + 3)) begin
        n_cmp++; n_err++; abort = 1;
        $display("FAIL rnd_timeout c%0d: if_age=%0d mem_age=%0d limit=%0d", c, iage, mage, 6 * (LAT + 3));
      end
      @(posedge clk); #1;
    end
    bus.if_req = 1'b0; bus.mem_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.conflict_cnt !== (STATS ? 16'(conf) : 16'd0)) begin n_err++;
      $display("FAIL rnd_conflict: got %0d want %0d", bus.conflict_cnt, STATS ? conf : 0); end
    @(posedge clk); #1;
  endtask

  initial begin
    ram_mem[32'h0040_0000] = 32'h2008_0005;
    ref_mem[32'h0040_0000] = 32'h2008_0005;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_store();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
